// File: rtl/serial_adder_n_pkg.sv
// ============================================================================
// Module : serial_adder_n_pkg
// Brief  : Shared types and helpers for the serial N-bit adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_adder_n_pkg;

  // Two-bit state encoding. Completion is a registered pulse, not a state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01
  } state_t;

  // Number of slice passes needed to cover the full operand width.
  function automatic int num_steps(input int width, input int step);
    return width / step;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_adder_n_if.sv
// ============================================================================
// Module : serial_adder_n_if
// Brief  : Start/busy/done handshake and operand/result bus of the adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;

  // Controller side: issues requests, observes status and result.
  modport master (
    output start, a, b, ci,
    input  busy, done, s, co
  );

  // Adder side.
  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder_n_slice.sv
// ============================================================================
// Module : serial_adder_n_slice
// Brief  : Combinational STEP-bit ripple adder built from one-bit full adders.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder_n_slice #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic            ci,
  output logic [STEP-1:0] s,
  output logic            co
);
  logic [STEP:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < STEP; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[STEP];

endmodule

`default_nettype wire

// File: rtl/serial_adder_n.sv
// ============================================================================
// Module : serial_adder_n
// Brief  : Multi-cycle WIDTH-bit adder (a + b + ci), STEP bits per clock,
//          with start/busy/done handshake. Results update only on completion.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic             clk,
  input logic             rst,
  serial_adder_n_if.slave bus
);
  localparam int NSTEPS = num_steps(WIDTH, STEP);
  localparam int CNT_W  = $clog2(NSTEPS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEPS - 1);

  if (WIDTH < 1 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
    $error("serial_adder_n: STEP must divide WIDTH and satisfy 1 <= STEP <= WIDTH");
  end

  state_t             r_state;
  state_t             w_state_nx;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_s;
  logic               r_co;
  logic               r_done;
  logic [STEP-1:0]    w_sum;
  logic               w_slice_co;
  // Slice sum concatenated above the result: the upper WIDTH bits are the
  // result shifted right by STEP with the new sum in the top. Written this
  // way so STEP == WIDTH needs no degenerate part-select.
  logic [WIDTH+STEP-1:0] w_res_cat;

  serial_adder_n_slice #(.STEP(STEP)) u_slice (
    .a  (r_a[STEP-1:0]),
    .b  (r_b[STEP-1:0]),
    .ci (r_carry),
    .s  (w_sum),
    .co (w_slice_co)
  );

  assign w_res_cat = {w_sum, r_res};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state: accept a start only when idle, finish on the last slice pass.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept   = 1'b1;
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_last     = 1'b1;
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Operand/result shift registers, carry, pass counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= bus.b;
        r_res   <= '0;
        r_carry <= bus.ci;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_a     <= r_a >> STEP;
        r_b     <= r_b >> STEP;
        r_res   <= w_res_cat[WIDTH+STEP-1:STEP];
        r_carry <= w_slice_co;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_s  <= w_res_cat[WIDTH+STEP-1:STEP];
          r_co <= w_slice_co;
        end
      end
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = r_done;
  assign bus.s    = r_s;
  assign bus.co   = r_co;

endmodule

`default_nettype wire
